// File: rtl/matvec_pe.sv
// matvec_pe: matrix-row x vector processing element.
//
// Accepts one dot-product job per start. The job's row length and upstream partial
// sum are captured when start is accepted. The PE then takes one (a_data, v_data)
// pair per accepted beat, accumulates the signed products on top of the partial sum,
// and presents the reduced result on a valid/ready output.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   start, size, acc_in job launch, row length (1..MAX_N), upstream partial sum
//   abort               synchronous cancel; wins over everything, any state -> IDLE
//   in_valid/in_ready   input beat handshake (a_data = M[row][k], v_data = V[k])
//   out_valid/out_ready result handshake, out_data = dot product + acc_in
//   busy                state != IDLE
//   done                1-cycle pulse in the cycle after the output handshake
//   err                 1-cycle pulse after a start with an illegal size
//   ovf                 result clamped/wrapped; sticky until the next accepted start
//   dbg_state_o         current FSM state (0 IDLE, 1 RUN, 2 OUT)
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that edge. out_data is
// registered and does not change while out_valid is high.
module matvec_pe #(
    parameter int DW    = 8,
    parameter int MAX_N = 8,
    parameter int OUT_W = 16,
    parameter int SAT   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(MAX_N+1)-1:0] size,
    input  logic [OUT_W-1:0]           acc_in,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              a_data,
    input  logic [DW-1:0]              v_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       ovf,
    output logic [1:0]                 dbg_state_o
);

    localparam int SW    = $clog2(MAX_N + 1);
    localparam int PW    = 2 * DW + $clog2(MAX_N);
    // One extra bit over the worst-case sum of MAX_N products or a full-range acc_in.
    localparam int ACC_W = ((PW > OUT_W) ? PW : OUT_W) + 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [SW-1:0]           count_q;
    logic [SW-1:0]           size_q;
    logic [OUT_W-1:0]        out_data_q;
    logic                    ovf_q;
    logic                    done_q;
    logic                    err_q;

    logic signed [2*DW-1:0]  a_ext;
    logic signed [2*DW-1:0]  v_ext;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] sum_d;
    logic [OUT_W-1:0]        out_data_d;
    logic                    ovf_d;
    logic                    size_ok;
    logic                    last_beat;

    // Operands are widened before the multiply so the product keeps all 2*DW bits.
    assign a_ext = {{DW{a_data[DW-1]}}, a_data};
    assign v_ext = {{DW{v_data[DW-1]}}, v_data};
    assign prod  = a_ext * v_ext;
    assign sum_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    assign size_ok   = (size != '0) && (size <= SW'(MAX_N));
    assign last_beat = (count_q == size_q - SW'(1));

    // Reduce the final sum to OUT_W: clamp when SAT is set, otherwise keep the low bits.
    always_comb begin
        out_data_d = sum_d[OUT_W-1:0];
        ovf_d      = (sum_d > OUT_MAX) || (sum_d < OUT_MIN);
        if (SAT != 0) begin
            if (sum_d > OUT_MAX) begin
                out_data_d = OUT_MAX[OUT_W-1:0];
            end else if (sum_d < OUT_MIN) begin
                out_data_d = OUT_MIN[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            size_q     <= '0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (size_ok) begin
                                size_q  <= size;
                                acc_q   <= {{(ACC_W-OUT_W){acc_in[OUT_W-1]}}, acc_in};
                                count_q <= '0;
                                ovf_q   <= 1'b0;
                                state_q <= S_RUN;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (in_valid) begin
                            acc_q   <= sum_d;
                            count_q <= count_q + SW'(1);
                            if (last_beat) begin
                                out_data_q <= out_data_d;
                                ovf_q      <= ovf_d;
                                state_q    <= S_OUT;
                            end
                        end
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign out_valid   = (state_q == S_OUT);
    assign busy        = (state_q != S_IDLE);
    assign out_data    = out_data_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matvec_pe.sv
// Directed bench for matvec_pe. Two instances share all inputs: dut (SAT=1) and
// dut_w (SAT=0). Inputs change 1 ns after a rising edge; outputs are sampled at the
// same point, so they show the state reached at that edge.
module tb_matvec_pe;

  logic              clk;
  logic              reset;
  logic              start;
  logic [3:0]        size;
  logic [15:0]       acc_in;
  logic              abort;
  logic              in_valid;
  logic [7:0]        a_data;
  logic [7:0]        v_data;
  logic              out_ready;

  logic              in_ready, out_valid, busy, done, err, ovf;
  logic signed [15:0] out_data;
  logic [1:0]        dbg_state;
  logic              w_in_ready, w_out_valid, w_busy, w_done, w_err, w_ovf;
  logic signed [15:0] w_out_data;
  logic [1:0]        w_dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  matvec_pe #(.DW(8), .MAX_N(8), .OUT_W(16), .SAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size), .acc_in(acc_in),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data),
    .v_data(v_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .err(err), .ovf(ovf),
    .dbg_state_o(dbg_state)
  );

  matvec_pe #(.DW(8), .MAX_N(8), .OUT_W(16), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .size(size), .acc_in(acc_in),
    .abort(abort), .in_valid(in_valid), .in_ready(w_in_ready), .a_data(a_data),
    .v_data(v_data), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .busy(w_busy), .done(w_done), .err(w_err), .ovf(w_ovf),
    .dbg_state_o(w_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] n, input logic [15:0] acc);
    start  = 1'b1;
    size   = n;
    acc_in = acc;
    step();
    start  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 0; size = 0; acc_in = 0; abort = 0;
    in_valid = 0; a_data = 0; v_data = 0; out_ready = 0;
    step(); step();
    reset = 1'b1;
    step();
    chk_cnt++; if ({in_ready, out_valid, busy, done, err, ovf} !== 6'b0) $display("FAIL reset_flags got %b exp 000000", {in_ready, out_valid, busy, done, err, ovf}); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'sd0) $display("FAIL reset_data got %0d exp 0", out_data); else pass_cnt++;
    chk_cnt++; if (dbg_state !== 2'd0 || w_dbg_state !== 2'd0) $display("FAIL reset_state got %0d/%0d exp 0", dbg_state, w_dbg_state); else pass_cnt++;
  endtask

  // 10 + 1*4 + 2*5 + 3*6 = 42; result at cycle 4, done at cycle 5
  task automatic test_basic();
    int av[3] = '{1, 2, 3};
    int vv[3] = '{4, 5, 6};
    out_ready = 1'b1;
    launch(4'd3, 16'd10);
    chk_cnt++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL basic_run got busy=%b in_ready=%b exp 1/1", busy, in_ready); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a_data = 8'(av[k]); v_data = 8'(vv[k]);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid beat %0d got 1 exp 0", k); else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_out got out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'sd42 || w_out_data !== 16'sd42) $display("FAIL basic_data got %0d/%0d exp 42", out_data, w_out_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b exp 0", ovf); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done got done=%b out_valid=%b busy=%b exp 1/0/0", done, out_valid, busy); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else pass_cnt++;
  endtask

  // 8 * (-128 * -128) = 131072: clamps to 32767, wraps to 0
  task automatic test_overflow();
    out_ready = 1'b0;
    launch(4'd8, 16'd0);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; a_data = 8'h80; v_data = 8'h80;
      step();
    end
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || w_out_valid !== 1'b1) $display("FAIL ovf_valid got %b/%b exp 1/1", out_valid, w_out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'sd32767) $display("FAIL ovf_sat_data got %0d exp 32767", out_data); else pass_cnt++;
    chk_cnt++; if (w_out_data !== 16'sd0) $display("FAIL ovf_wrap_data got %0d exp 0", w_out_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b1 || w_ovf !== 1'b1) $display("FAIL ovf_flag got %b/%b exp 1/1", ovf, w_ovf); else pass_cnt++;
    out_ready = 1'b1;
    step();
    step();
    chk_cnt++; if (ovf !== 1'b1 || busy !== 1'b0) $display("FAIL ovf_sticky got ovf=%b busy=%b exp 1/0", ovf, busy); else pass_cnt++;
  endtask

  // -5 + 3*2 + (-2)*5 + 7*(-4) + 1*9 = -28, with bubbles and downstream stall
  task automatic test_bubbles_stall();
    int av[4] = '{3, -2, 7, 1};
    int vv[4] = '{2, 5, -4, 9};
    out_ready = 1'b0;
    launch(4'd4, 16'hFFFB);
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL stall_ovf_clear got %b exp 0", ovf); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        in_valid = 1'b1; a_data = 8'(av[i/2]); v_data = 8'(vv[i/2]);
      end else begin
        in_valid = 1'b0; a_data = 8'($urandom_range(0, 255)); v_data = 8'($urandom_range(0, 255));
      end
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_early_valid step %0d got 1 exp 0", i); else pass_cnt++;
      step();
    end
    // keep offering garbage beats while the result waits
    in_valid = 1'b1; a_data = 8'd100; v_data = 8'd100;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL stall_hold cyc %0d got out_valid=%b in_ready=%b busy=%b exp 1/0/1", i, out_valid, in_ready, busy); else pass_cnt++;
      chk_cnt++; if (out_data !== -16'sd28 || w_out_data !== -16'sd28) $display("FAIL stall_data cyc %0d got %0d/%0d exp -28", i, out_data, w_out_data); else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_cnt++; if (done !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_done got done=%b out_valid=%b exp 1/0", done, out_valid); else pass_cnt++;
    step();
  endtask

  // size 0 and 9 rejected; then 100 + (-1)*7 + 5*3 = 108
  task automatic test_illegal_size();
    launch(4'd0, 16'd55);
    chk_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_size0 got err=%b busy=%b exp 1/0", err, busy); else pass_cnt++;
    step();
    chk_cnt++; if (err !== 1'b0) $display("FAIL err_pulse got %b exp 0", err); else pass_cnt++;
    launch(4'd9, 16'd55);
    chk_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_size9 got err=%b busy=%b exp 1/0", err, busy); else pass_cnt++;
    launch(4'd2, 16'd100);
    chk_cnt++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL err_legal got err=%b busy=%b exp 0/1", err, busy); else pass_cnt++;
    in_valid = 1'b1; a_data = 8'hFF; v_data = 8'd7; step();
    a_data = 8'd5; v_data = 8'd3; step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== 16'sd108) $display("FAIL err_next_data got valid=%b data=%0d exp 1/108", out_valid, out_data); else pass_cnt++;
    step(); step();
  endtask

  // reset mid-run, then 1 + 2*4 + 3*5 = 24
  task automatic test_reset_mid_run();
    launch(4'd4, 16'd50);
    in_valid = 1'b1; a_data = 8'd10; v_data = 8'd10; step(); step();
    reset = 1'b0;
    #1;
    chk_cnt++; if ({in_ready, out_valid, busy, done, err, ovf} !== 6'b0) $display("FAIL rst_mid_flags got %b exp 000000", {in_ready, out_valid, busy, done, err, ovf}); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'sd0 || w_out_data !== 16'sd0) $display("FAIL rst_mid_data got %0d/%0d exp 0", out_data, w_out_data); else pass_cnt++;
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    launch(4'd2, 16'd1);
    in_valid = 1'b1; a_data = 8'd2; v_data = 8'd4; step();
    a_data = 8'd3; v_data = 8'd5; step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== 16'sd24) $display("FAIL rst_fresh_data got valid=%b data=%0d exp 1/24", out_valid, out_data); else pass_cnt++;
    step(); step();
  endtask

  // start during RUN ignored (6+7 = 13); abort during OUT drops the result
  task automatic test_start_busy_abort();
    out_ready = 1'b0;
    launch(4'd2, 16'd0);
    in_valid = 1'b1; a_data = 8'd6; v_data = 8'd1;
    start = 1'b1; size = 4'd5; acc_in = 16'd999;
    step();
    start = 1'b0;
    chk_cnt++; if (err !== 1'b0 || in_ready !== 1'b1) $display("FAIL busy_start got err=%b in_ready=%b exp 0/1", err, in_ready); else pass_cnt++;
    a_data = 8'd7; v_data = 8'd1; step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== 16'sd13) $display("FAIL busy_data got valid=%b data=%0d exp 1/13", out_valid, out_data); else pass_cnt++;
    abort = 1'b1; step();
    abort = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_out got out_valid=%b busy=%b done=%b exp 0/0/0", out_valid, busy, done); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'sd13) $display("FAIL abort_keep_data got %0d exp 13", out_data); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", done); else pass_cnt++;
    out_ready = 1'b1;
    launch(4'd1, 16'd0);
    in_valid = 1'b1; a_data = 8'd2; v_data = 8'd3; step();
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1 || out_data !== 16'sd6) $display("FAIL abort_next_data got valid=%b data=%0d exp 1/6", out_valid, out_data); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1) $display("FAIL abort_next_done got %b exp 1", done); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_bubbles_stall();
    test_illegal_size();
    test_reset_mid_run();
    test_start_busy_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
